reg_access_arbiter: RTL and testbench

- Shares one register-bus slave port among CNT requesters, e.g. a debug master, a CPU bridge and DMA config ports.
- Arbitration is round-robin. The block keeps one transaction outstanding at a time and holds the grant until the slave acknowledges or a timeout fires.
- It sits in front of the generated register block and returns each response to the requester that issued it.
- Flattened request payloads are selected with one-hot grant through `priority_mux`.

---
 rtl/reg_arb_pkg.sv | 19 +
 rtl/priority_mux.sv | 25 ++
 rtl/reg_access_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// reg_arb_pkg : shared types and constants for reg_access_arbiter
// Revision    : 1.0
// ------------------------------------------------------------------
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // A timed-out access reports err=1 with all-zero read data.
  localparam logic c_timeout_err        = 1'b1;
  localparam logic c_timeout_rdata_bit  = 1'b0;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/priority_mux.sv
`default_nettype none
// ------------------------------------------------------------------
// priority_mux : selects one W-bit slice of a flattened bus by select,
//                lowest set select bit wins.  Revision : 1.0
// ------------------------------------------------------------------
module priority_mux #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0]   i_sel,
  input  logic [N*W-1:0] i_data,
  output logic [W-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    for (int n = N - 1; n >= 0; n--) begin
      if (i_sel[n]) begin
        o_data = i_data[n*W +: W];
      end
    end
  end

endmodule : priority_mux
`default_nettype wire

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// reg_access_arbiter : round-robin sharing of one register-bus slave
//                      among CNT requesters.  Revision : 1.0
// ------------------------------------------------------------------
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int CNT        = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT-1:0]            req_vld,
  output logic [CNT-1:0]            req_rdy,
  input  logic [CNT-1:0]            req_wr,
  input  logic [ADDR_WIDTH*CNT-1:0] req_addr,
  input  logic [DATA_WIDTH*CNT-1:0] req_wdata,
  output logic [CNT-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_vld,
  output logic                      m_wr,
  output logic [ADDR_WIDTH-1:0]     m_addr,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  input  logic                      m_ack,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic                      m_err
);

  localparam int c_PW  = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int c_CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int c_PLW = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [c_PW:0]   c_CNT     = (c_PW + 1)'(CNT);
  localparam logic [c_PW-1:0] c_LAST    = c_PW'(CNT - 1);
  localparam logic [c_CW-1:0] c_TO_LAST = (TIMEOUT > 0) ? c_CW'(TIMEOUT - 1) : '0;

  arb_state_t                r_state;
  arb_state_t                w_next;
  logic [c_PW-1:0]           r_ptr;
  logic [CNT-1:0]            r_gnt;
  logic [c_CW-1:0]           r_cnt;
  logic                      r_cur_wr;
  logic                      r_m_vld;
  logic                      r_m_wr;
  logic [ADDR_WIDTH-1:0]     r_m_addr;
  logic [DATA_WIDTH-1:0]     r_m_wdata;
  logic [DATA_WIDTH-1:0]     r_rsp_rdata;
  logic                      r_rsp_err;

  logic                      w_any;
  logic                      w_to;
  logic [CNT-1:0]            w_rot;
  logic [c_PW-1:0]           w_off;
  logic [c_PW:0]             w_sum;
  logic [c_PW-1:0]           w_gidx;
  logic [c_PW-1:0]           w_ptr_nxt;
  logic [CNT-1:0]            w_gnt;
  logic [c_PLW*CNT-1:0]      w_pl_flat;
  logic [c_PLW-1:0]          w_sel_pl;
  logic                      w_sel_wr;

  assign w_any = |req_vld;
  assign w_to  = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);

  // Rotate requests so ptr lands at bit 0, find the first one, rotate back.
  always_comb begin
    w_rot = CNT'({req_vld, req_vld} >> r_ptr);
    w_off = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = c_PW'(i);
      end
    end
    w_sum = {1'b0, w_off} + {1'b0, r_ptr};
    if (w_sum >= c_CNT) begin
      w_sum = w_sum - c_CNT;
    end
    w_gidx = w_sum[c_PW-1:0];
    w_gnt  = '0;
    if (w_any) begin
      w_gnt[w_gidx] = 1'b1;
    end
    w_ptr_nxt = (w_gidx == c_LAST) ? '0 : w_gidx + c_PW'(1);
  end

  genvar c;
  generate
    for (c = 0; c < CNT; c++) begin : g_flat
      assign w_pl_flat[c*c_PLW +: c_PLW] =
        {req_wr[c], req_addr[c*ADDR_WIDTH +: ADDR_WIDTH], req_wdata[c*DATA_WIDTH +: DATA_WIDTH]};
    end
  endgenerate

  priority_mux #(.N(CNT), .W(c_PLW)) u_pl_mux (
    .i_sel  (w_gnt),
    .i_data (w_pl_flat),
    .o_data (w_sel_pl)
  );

  priority_mux #(.N(CNT), .W(1)) u_wr_mux (
    .i_sel  (w_gnt),
    .i_data (req_wr),
    .o_data (w_sel_wr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    req_rdy = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_rdy = w_gnt;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (m_ack || w_to) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_cur_wr    <= 1'b0;
      r_m_vld     <= 1'b0;
      r_m_wr      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= '0;
            r_m_vld   <= 1'b1;
            r_m_wr    <= w_sel_wr;
            r_cur_wr  <= w_sel_pl[c_PLW-1];
            r_m_addr  <= w_sel_pl[DATA_WIDTH +: ADDR_WIDTH];
            r_m_wdata <= w_sel_pl[DATA_WIDTH-1:0];
          end
        end
        ACCESS: begin
          // An ack in the final timeout cycle takes precedence.
          if (m_ack) begin
            r_m_vld     <= 1'b0;
            r_rsp_rdata <= r_cur_wr ? '0 : m_rdata;
            r_rsp_err   <= m_err;
          end else if (w_to) begin
            r_m_vld     <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{c_timeout_rdata_bit}};
            r_rsp_err   <= c_timeout_err;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_vld   = (r_state == RESP) ? r_gnt : '0;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign m_vld     = r_m_vld;
  assign m_wr      = r_m_wr;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;

endmodule : reg_access_arbiter
`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_reg_access_arbiter : directed self-checking bench for the arbiter
// Revision              : 1.0
// ------------------------------------------------------------------
module tb_reg_access_arbiter;

  localparam int CNT = 5;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CNT-1:0]    req_vld, req_rdy, req_wr, rsp_vld;
  logic [AW*CNT-1:0] req_addr;
  logic [DW*CNT-1:0] req_wdata;
  logic [DW-1:0]     rsp_rdata, m_wdata, m_rdata;
  logic              rsp_err, m_vld, m_wr, m_ack, m_err;
  logic [AW-1:0]     m_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc      = 0;
  int prev_acc = 0;

  logic [31:0] a_tab [CNT] = '{32'h0100, 32'h0204, 32'h0010, 32'h0308, 32'h040C};
  logic [31:0] d_tab [CNT] = '{32'hD000_0000, 32'hD000_0011, 32'hD000_0022, 32'hD000_0033, 32'hD000_0044};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_access_arbiter #(
    .CNT(CNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_vld(m_vld), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":req_rdy"},   64'(req_rdy),   64'h0);
    check({tag, ":rsp_vld"},   64'(rsp_vld),   64'h0);
    check({tag, ":rsp_rdata"}, 64'(rsp_rdata), 64'h0);
    check({tag, ":rsp_err"},   64'(rsp_err),   64'h0);
    check({tag, ":m_vld"},     64'(m_vld),     64'h0);
    check({tag, ":m_wr"},      64'(m_wr),      64'h0);
    check({tag, ":m_addr"},    64'(m_addr),    64'h0);
    check({tag, ":m_wdata"},   64'(m_wdata),   64'h0);
  endtask

  // One transaction: accept now, ack in the k-th ACCESS cycle, check response.
  task automatic txn(input string tag, input logic [CNT-1:0] vld, input int g, input int k,
                     input logic [31:0] rd, input logic er, output int acc_cyc);
    logic [CNT-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    req_vld = vld;
    #1;
    check({tag, ":req_rdy"}, 64'(req_rdy), 64'(oh));
    acc_cyc = cyc;
    tick();
    req_vld = vld & ~oh;
    #1;
    check({tag, ":m_vld"},  64'(m_vld),  64'h1);
    check({tag, ":m_addr"}, 64'(m_addr), 64'(a_tab[g]));
    check({tag, ":m_wr"},   64'(m_wr),   64'(req_wr[g]));
    if (req_wr[g]) check({tag, ":m_wdata"}, 64'(m_wdata), 64'(d_tab[g]));
    for (int i = 1; i < k; i++) begin
      tick();
      check({tag, ":m_vld_hold"}, 64'(m_vld), 64'h1);
    end
    m_ack = 1'b1;
    m_rdata = rd;
    m_err = er;
    tick();
    m_ack = 1'b0;
    m_rdata = '0;
    m_err = 1'b0;
    #1;
    check({tag, ":rsp_vld"},   64'(rsp_vld),   64'(oh));
    check({tag, ":rsp_rdata"}, 64'(rsp_rdata), req_wr[g] ? 64'h0 : 64'(rd));
    check({tag, ":rsp_err"},   64'(rsp_err),   64'(er));
    check({tag, ":m_vld_low"}, 64'(m_vld),     64'h0);
    tick();
    check({tag, ":rsp_vld_pulse"}, 64'(rsp_vld), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < CNT; c++) begin
      req_addr[c*AW +: AW]  = a_tab[c];
      req_wdata[c*DW +: DW] = d_tab[c];
    end
    rst = 1'b1; req_vld = '0; req_wr = '0;
    m_ack = 1'b0; m_err = 1'b0; m_rdata = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    txn("rd1", 5'b00100, 2, 3, 32'hA5A5_0001, 1'b0, acc);
    txn("skip0", 5'b00011, 0, 1, 32'h0000_0011, 1'b0, acc);
    txn("skip1", 5'b00010, 1, 1, 32'h0000_0022, 1'b0, acc);
    req_wr = 5'b01000;
    txn("wr3", 5'b01000, 3, 1, 32'hFFFF_FFFF, 1'b0, acc);
    req_wr = '0;

    // Reset while the slave access is in flight, then a late ack.
    req_vld = 5'b00100;
    #1;
    check("mid:req_rdy", 64'(req_rdy), 64'h04);
    tick();
    req_vld = '0;
    #1;
    check("mid:m_vld", 64'(m_vld), 64'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ack = 1'b1;
    m_rdata = 32'hDEAD_BEEF;
    #1;
    check_all_zero("mid_rst");
    tick();
    m_ack = 1'b0;
    m_rdata = '0;
    #1;
    check("mid:late_ack_rsp", 64'(rsp_vld), 64'h0);
    check("mid:late_ack_mvld", 64'(m_vld), 64'h0);

    for (int i = 0; i < 6; i++) begin
      prev_acc = acc;
      txn("rr", 5'b11111, i % CNT, 1, 32'h0000_0100 + 32'(i), 1'b0, acc);
      if (i > 0) check("rr:spacing", 64'(acc - prev_acc), 64'd3);
    end

    // Timeout with no ack: m_vld for exactly TO cycles.
    req_vld = 5'b00010;
    #1;
    check("to:req_rdy", 64'(req_rdy), 64'h02);
    tick();
    req_vld = '0;
    for (int i = 0; i < TO; i++) begin
      #1;
      check("to:m_vld", 64'(m_vld), 64'h1);
      tick();
    end
    #1;
    check("to:m_vld_low", 64'(m_vld),     64'h0);
    check("to:rsp_vld",   64'(rsp_vld),   64'h02);
    check("to:rsp_err",   64'(rsp_err),   64'h1);
    check("to:rsp_rdata", 64'(rsp_rdata), 64'h0);
    tick();
    m_ack = 1'b1;
    m_err = 1'b0;
    m_rdata = 32'h0000_0077;
    #1;
    check("to:idle_rsp", 64'(rsp_vld), 64'h0);
    tick();
    m_ack = 1'b0;
    m_rdata = '0;
    #1;
    check("to:stray_ack_rsp",  64'(rsp_vld), 64'h0);
    check("to:stray_ack_mvld", 64'(m_vld),   64'h0);
    check("to:stray_ack_err",  64'(rsp_err), 64'h1);

    txn("tie_err", 5'b00100, 2, TO, 32'h0000_1234, 1'b1, acc);
    txn("tie_ok",  5'b01000, 3, TO, 32'h0000_5678, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_access_arbiter
`default_nettype wire
